// File: rtl/alu_cmp_stage.sv
// alu_cmp_stage: registered compare/pass stage downstream of adder32.
// Evaluates PASS/CMPEQ/CMPLT/CMPLE from the adder sum and Z/V/N flags and
// buffers results behind a valid/ready handshake with a main + skid register.
// Keeps a saturating count of accepted beats that carried signed overflow.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready decoded from state only)
//   sum_in, z_in, v_in,   adder32 sum and flags
//   n_in, op              op: 00 PASS, 01 CMPEQ, 10 CMPLT, 11 CMPLE
//   out_valid/out_ready   downstream handshake
//   out_data, out_flags   result and {Z,V,N} captured with the beat
//   ovf_clr, ovf_count    synchronous clear / saturating overflow count
module alu_cmp_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             z_in,
  input  logic             v_in,
  input  logic             n_in,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_flags,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [2:0]       main_flags_q, main_flags_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [2:0]       skid_flags_q, skid_flags_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  logic [WIDTH-1:0] result;
  logic [2:0]       flags_in;
  logic             accept;

  assign flags_in = {z_in, v_in, n_in};

  // Compare results are a single bit, zero-extended to the data width.
  always_comb begin
    result = '0;
    case (op)
      2'b00:   result    = sum_in;
      2'b01:   result[0] = z_in;
      2'b10:   result[0] = n_in ^ v_in;
      default: result[0] = z_in | (n_in ^ v_in);
    endcase
  end

  // Handshake outputs depend on state only, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != StSkid);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_flags_d = main_flags_q;
    skid_data_d  = skid_data_q;
    skid_flags_d = skid_flags_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d      = StFull;
          main_data_d  = result;
          main_flags_d = flags_in;
        end
      end
      StFull: begin
        if (accept && out_ready) begin
          // Emit and accept in the same cycle: main refills without a bubble.
          main_data_d  = result;
          main_flags_d = flags_in;
        end else if (accept) begin
          state_d      = StSkid;
          skid_data_d  = result;
          skid_flags_d = flags_in;
        end else if (out_ready) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (out_ready) begin
          state_d      = StFull;
          main_data_d  = skid_data_q;
          main_flags_d = skid_flags_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Clear takes priority over a same-cycle increment; the count never wraps.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr) begin
      ovf_count_d = '0;
    end else if (accept && v_in && (ovf_count_q != CntMax)) begin
      ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      main_data_q  <= '0;
      main_flags_q <= '0;
      skid_data_q  <= '0;
      skid_flags_q <= '0;
      ovf_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_flags_q <= main_flags_d;
      skid_data_q  <= skid_data_d;
      skid_flags_q <= skid_flags_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign out_data  = main_data_q;
  assign out_flags = main_flags_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_alu_cmp_stage.sv
// Directed-vector bench for alu_cmp_stage with hand-computed expectations.
module tb_alu_cmp_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum_in;
  logic        z_in;
  logic        v_in;
  logic        n_in;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;
  logic        ovf_clr;
  logic [7:0]  ovf_count;

  int unsigned n_checks = 0;
  int unsigned n_passed = 0;

  alu_cmp_stage #(
    .WIDTH(32),
    .CNT_W(8)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .z_in      (z_in),
    .v_in      (v_in),
    .n_in      (n_in),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one beat for a single cycle; returns 1 ns after the capturing edge.
  task automatic send(input logic [31:0] s, input logic z, input logic v, input logic n,
                      input logic [1:0] o);
    in_valid = 1'b1;
    sum_in   = s;
    z_in     = z;
    v_in     = v;
    n_in     = n;
    op       = o;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    v_in     = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sum_in    = '0;
    z_in      = 1'b0;
    v_in      = 1'b0;
    n_in      = 1'b0;
    op        = 2'b00;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_ovf_count", 32'(ovf_count), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // PASS
    send(32'h0000_0088, 1'b0, 1'b0, 1'b0, 2'b00);
    check("pass_valid", 32'(out_valid), 32'd1);
    check("pass_data",  out_data,       32'h0000_0088);
    check("pass_flags", 32'(out_flags), 32'd0);
    idle(1);
    check("pass_drained", 32'(out_valid), 32'd0);

    // CMPLT with overflow: N^V = 1
    send(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 2'b10);
    check("lt_ovf_data",  out_data,       32'd1);
    check("lt_ovf_flags", 32'(out_flags), 32'b010);
    check("lt_ovf_count", 32'(ovf_count), 32'd1);

    // Back-to-back compares, out_ready=1 keeps stage streaming
    send(32'h0, 1'b1, 1'b0, 1'b0, 2'b01);
    check("eq_z1",    out_data,       32'd1);
    check("eq_flags", 32'(out_flags), 32'b100);
    send(32'h0, 1'b1, 1'b0, 1'b0, 2'b11);
    check("le_z1", out_data, 32'd1);
    send(32'h5, 1'b0, 1'b0, 1'b0, 2'b11);
    check("le_z0", out_data, 32'd0);
    send(32'h5, 1'b0, 1'b0, 1'b0, 2'b01);
    check("eq_z0", out_data, 32'd0);
    send(32'h8000_0000, 1'b0, 1'b0, 1'b1, 2'b10);
    check("lt_n1v0", out_data, 32'd1);
    send(32'h8000_0000, 1'b0, 1'b1, 1'b1, 2'b10);
    check("lt_n1v1", out_data, 32'd0);
    check("lt_count", 32'(ovf_count), 32'd2);
    idle(1);

    // Backpressure into skid, then drain in order
    out_ready = 1'b0;
    send(32'h11, 1'b0, 1'b0, 1'b0, 2'b00);
    check("bp_first_ready", 32'(in_ready), 32'd1);
    check("bp_first_data",  out_data,      32'h11);
    send(32'h22, 1'b0, 1'b0, 1'b0, 2'b00);
    check("bp_skid_ready", 32'(in_ready),  32'd0);
    check("bp_skid_valid", 32'(out_valid), 32'd1);
    check("bp_skid_data",  out_data,       32'h11);
    idle(2);
    check("bp_hold_data", out_data, 32'h11);
    out_ready = 1'b1;
    idle(1);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_data",  out_data,       32'h22);
    check("bp_second_ready", 32'(in_ready),  32'd1);
    idle(1);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Saturation: count is 2, 253 more reaches 0xFF, further beats hold it
    for (int i = 0; i < 252; i++) send(32'h1, 1'b0, 1'b1, 1'b0, 2'b00);
    check("sat_fe", 32'(ovf_count), 32'hFE);
    for (int i = 0; i < 8; i++) send(32'h1, 1'b0, 1'b1, 1'b0, 2'b00);
    check("sat_ff", 32'(ovf_count), 32'hFF);
    ovf_clr = 1'b1;
    send(32'h1, 1'b0, 1'b1, 1'b0, 2'b00);
    ovf_clr = 1'b0;
    check("clr_wins", 32'(ovf_count), 32'd0);
    send(32'h1, 1'b0, 1'b1, 1'b0, 2'b00);
    check("after_clr", 32'(ovf_count), 32'd1);
    idle(1);

    // Reset while in SKID
    out_ready = 1'b0;
    send(32'hAA, 1'b0, 1'b0, 1'b0, 2'b00);
    send(32'hBB, 1'b0, 1'b0, 1'b0, 2'b00);
    check("pre_rst_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_data",  out_data,       32'd0);
    check("mid_rst_count", 32'(ovf_count), 32'd0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(out_valid), 32'd0);
    send(32'hCC, 1'b0, 1'b0, 1'b0, 2'b00);
    check("post_rst_data", out_data, 32'hCC);
    idle(1);
    check("post_rst_no_stale", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
